// File: rtl/tt_uart_pkg.sv
// Shared UART definitions: receive FSM states, frame geometry and parity helper.
// Intended to be reused by the transmit side as well.
package tt_uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int IDX_W     = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/tt_uart_rx_if.sv
// Consumer-side bundle of the UART receiver: byte, valid/read handshake and status flags.
interface tt_uart_rx_if;
   import tt_uart_pkg::*;

   logic                 rd_i;
   logic [DATA_BITS-1:0] data_o;
   logic                 valid_o;
   logic                 frame_err_o;
   logic                 parity_err_o;
   logic                 overrun_o;
   logic                 busy_o;

   modport slave  (input  rd_i,
                   output data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o);
   modport master (output rd_i,
                   input  data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o);
endinterface

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module tt_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // metastability chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RST_VAL;
         q_r    <= RST_VAL;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/tt_uart_rx.sv
// Oversampling 8N1 UART receiver with valid/read handshake, frame error and overrun flags.
// Defining TT_UART_RX_PARITY_EN adds an even-parity bit between the data and the stop bit.
import tt_uart_pkg::*;

module tt_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         rx_i,
   tt_uart_rx_if.slave  bus
);

   localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_C = IDX_W'(DATA_BITS - 1);

   rx_state_e            state_r;
   logic [CNT_W-1:0]     bit_cnt_r;
   logic [IDX_W-1:0]     bit_idx_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic [DATA_BITS-1:0] data_r;
   logic                 rx_prev_r;
   logic                 valid_r;
   logic                 frame_err_r;
   logic                 overrun_r;
   logic                 rx_s;
   logic                 rd_accept_s;
   rx_state_e            after_data_s;
`ifdef TT_UART_RX_PARITY_EN
   logic                 parity_err_r;
`endif

   tt_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_i),
      .q     (rx_s)
   );

   assign rd_accept_s = bus.rd_i & valid_r;
`ifdef TT_UART_RX_PARITY_EN
   assign after_data_s = PARITY;
`else
   assign after_data_s = STOP;
`endif

   // receive FSM, bit timing, output byte register and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         bit_cnt_r    <= '0;
         bit_idx_r    <= '0;
         shreg_r      <= '0;
         data_r       <= '0;
         rx_prev_r    <= 1'b1;
         valid_r      <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         rx_prev_r   <= rx_s;
         frame_err_r <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
         parity_err_r <= 1'b0;
`endif
         if (rd_accept_s) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
         end
         if (!ena) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            bit_idx_r <= '0;
         end else begin
            case (state_r)
               IDLE: begin
                  bit_cnt_r <= '0;
                  bit_idx_r <= '0;
                  if (rx_prev_r && !rx_s) begin
                     state_r <= START;
                  end
               end
               START: begin
                  if (bit_cnt_r == HALF_C) begin
                     bit_cnt_r <= '0;
                     state_r   <= rx_s ? IDLE : DATA;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
               end
               DATA: begin
                  if (bit_cnt_r == FULL_C) begin
                     bit_cnt_r <= '0;
                     shreg_r   <= {rx_s, shreg_r[DATA_BITS-1:1]};
                     bit_idx_r <= bit_idx_r + IDX_W'(1);
                     if (bit_idx_r == LAST_C) begin
                        state_r <= after_data_s;
                     end
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
               end
`ifdef TT_UART_RX_PARITY_EN
               PARITY: begin
                  if (bit_cnt_r == FULL_C) begin
                     bit_cnt_r <= '0;
                     if (rx_s != even_parity(shreg_r)) begin
                        parity_err_r <= 1'b1;
                        state_r      <= WAIT_IDLE;
                     end else begin
                        state_r <= STOP;
                     end
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
               end
`endif
               STOP: begin
                  if (bit_cnt_r == FULL_C) begin
                     bit_cnt_r <= '0;
                     if (rx_s) begin
                        state_r <= IDLE;
                        // a read in this same cycle frees the slot for the new byte
                        if (!valid_r || rd_accept_s) begin
                           data_r  <= shreg_r;
                           valid_r <= 1'b1;
                        end else begin
                           overrun_r <= 1'b1;
                        end
                     end else begin
                        frame_err_r <= 1'b1;
                        state_r     <= WAIT_IDLE;
                     end
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
               end
               WAIT_IDLE: begin
                  bit_cnt_r <= '0;
                  if (rx_s) begin
                     state_r <= IDLE;
                  end
               end
               default: begin
                  state_r   <= IDLE;
                  bit_cnt_r <= '0;
               end
            endcase
         end
      end
   end

   assign bus.data_o      = data_r;
   assign bus.valid_o     = valid_r;
   assign bus.frame_err_o = frame_err_r;
   assign bus.overrun_o   = overrun_r;
   assign bus.busy_o      = (state_r != IDLE);
`ifdef TT_UART_RX_PARITY_EN
   assign bus.parity_err_o = parity_err_r;
`else
   assign bus.parity_err_o = 1'b0;
`endif

endmodule
